// File: rtl/hs_deserializer_sync_align.sv
// C-PHY HS lane deserializer: collects {flip,rotation,polarity} symbols into SYM_PER_WORD-wide
// words, optionally hunting for the sync word to establish word alignment first.
module hs_deserializer_sync_align #(
    parameter int                      SYM_PER_WORD = 7,
    parameter int                      ALIGN_EN     = 1,
    parameter logic [SYM_PER_WORD-1:0] SYNC_FLIP    = 7'b0111110,
    parameter logic [SYM_PER_WORD-1:0] SYNC_ROT     = 7'b1000001,
    parameter logic [SYM_PER_WORD-1:0] SYNC_POL     = 7'b1000001
) (
    input  logic                    RxSymClkHS,
    input  logic                    RstN,
    input  logic [2:0]              SerSym,
    input  logic                    SymValid,
    input  logic                    HSDeserEn,
    output logic [SYM_PER_WORD-1:0] RxFlip,
    output logic [SYM_PER_WORD-1:0] RxRotation,
    output logic [SYM_PER_WORD-1:0] RxPolarity,
    output logic                    WordValid,
    output logic                    SyncDet,
    output logic                    Locked
);

    localparam int             CW   = $clog2(SYM_PER_WORD);
    localparam logic [CW-1:0]  LAST = CW'(SYM_PER_WORD - 1);

    typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [SYM_PER_WORD-1:0] win_flip_q, win_rot_q, win_pol_q;
    logic [SYM_PER_WORD-1:0] win_flip_d, win_rot_d, win_pol_d;
    logic [SYM_PER_WORD-1:0] rx_flip_q, rx_rot_q, rx_pol_q;
    logic                    word_valid_q, sync_det_q;
    logic                    accept;
    logic                    sync_match;

    assign accept = HSDeserEn & SymValid;

    // Newest symbol enters at the MSB so bit0 ends up holding the first received symbol.
    assign win_flip_d = {SerSym[2], win_flip_q[SYM_PER_WORD-1:1]};
    assign win_rot_d  = {SerSym[1], win_rot_q[SYM_PER_WORD-1:1]};
    assign win_pol_d  = {SerSym[0], win_pol_q[SYM_PER_WORD-1:1]};

    assign sync_match = (win_flip_d == SYNC_FLIP) && (win_rot_d == SYNC_ROT) &&
                        (win_pol_d == SYNC_POL);

    always_ff @(posedge RxSymClkHS) begin
        if (!RstN) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            win_flip_q   <= '0;
            win_rot_q    <= '0;
            win_pol_q    <= '0;
            rx_flip_q    <= '0;
            rx_rot_q     <= '0;
            rx_pol_q     <= '0;
            word_valid_q <= 1'b0;
            sync_det_q   <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            sync_det_q   <= 1'b0;
            if (!HSDeserEn) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                win_flip_q <= '0;
                win_rot_q  <= '0;
                win_pol_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q    <= (ALIGN_EN != 0) ? HUNT : LOCKED;
                        cnt_q      <= '0;
                        win_flip_q <= '0;
                        win_rot_q  <= '0;
                        win_pol_q  <= '0;
                    end
                    HUNT: begin
                        if (accept) begin
                            win_flip_q <= win_flip_d;
                            win_rot_q  <= win_rot_d;
                            win_pol_q  <= win_pol_d;
                            if (sync_match) begin
                                state_q    <= LOCKED;
                                cnt_q      <= '0;
                                sync_det_q <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        // Once aligned, a sync pattern in the stream is ordinary data.
                        if (accept) begin
                            win_flip_q <= win_flip_d;
                            win_rot_q  <= win_rot_d;
                            win_pol_q  <= win_pol_d;
                            if (cnt_q == LAST) begin
                                rx_flip_q    <= win_flip_d;
                                rx_rot_q     <= win_rot_d;
                                rx_pol_q     <= win_pol_d;
                                word_valid_q <= 1'b1;
                                cnt_q        <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign RxFlip     = rx_flip_q;
    assign RxRotation = rx_rot_q;
    assign RxPolarity = rx_pol_q;
    assign WordValid  = word_valid_q;
    assign SyncDet    = sync_det_q;
    assign Locked     = (state_q == LOCKED);

endmodule
